// File: rtl/i2c_slave_ctrl_fsm_pkg.sv
// Shared types and constants for the I2C target-side sequencer.
package i2c_pkg;

    localparam int unsigned I2C_BYTE_BITS  = 8;
    localparam int unsigned I2C_ADDR_W     = 7;
    localparam int unsigned I2C_BIT_CNT_W  = 4;
    localparam logic [I2C_ADDR_W-1:0] I2C_GEN_CALL_ADDR = 7'h00;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_AACK,
        ST_WRITE,
        ST_WACK,
        ST_READ,
        ST_RACK
    } i2c_slv_state_e;

endpackage

// File: rtl/i2c_slave_ctrl_fsm_if.sv
// Sequencer-side bus bundle: edge pulses, line samples, shift-register
// handshake and status. The gen_call signal exists only when
// I2C_SLAVE_GEN_CALL_EN is defined.
interface i2c_slave_ctrl_fsm_if #(
    parameter int unsigned BYTE_CNT_W = 8
);
    import i2c_pkg::*;

    logic                          rx_edge;
    logic                          tx_edge;
    logic                          scl_in;
    logic                          sda_in;
    logic [I2C_ADDR_W-1:0]         own_addr;
    logic [I2C_BYTE_BITS-1:0]      rx_byte;
    logic                          rx_ready;

    logic                          sda_en;
    logic                          shift_en;
    logic                          shift_load_en;
    logic                          data_load_en;
    logic                          addr_match;
    logic                          rw;
    logic                          nack_rcvd;
    logic                          start_det;
    logic                          stop_det;
    logic                          busy;
    logic [BYTE_CNT_W-1:0]         byte_cnt;
    logic [I2C_BIT_CNT_W-1:0]      bit_cnt;
`ifdef I2C_SLAVE_GEN_CALL_EN
    logic                          gen_call;
`endif

    modport slave (
        input  rx_edge, tx_edge, scl_in, sda_in, own_addr, rx_byte, rx_ready,
        output sda_en, shift_en, shift_load_en, data_load_en, addr_match, rw,
               nack_rcvd, start_det, stop_det, busy, byte_cnt, bit_cnt
`ifdef I2C_SLAVE_GEN_CALL_EN
        , output gen_call
`endif
    );

    modport master (
        output rx_edge, tx_edge, scl_in, sda_in, own_addr, rx_byte, rx_ready,
        input  sda_en, shift_en, shift_load_en, data_load_en, addr_match, rw,
               nack_rcvd, start_det, stop_det, busy, byte_cnt, bit_cnt
`ifdef I2C_SLAVE_GEN_CALL_EN
        , input gen_call
`endif
    );

endinterface

// File: rtl/i2c_slave_ctrl_fsm_bus_cond_det.sv
// START / STOP detector: SDA edge while SCL held high across two samples.
module i2c_bus_cond_det (
    input  logic pclk,
    input  logic preset,
    input  logic scl_in,
    input  logic sda_in,
    output logic start_det,
    output logic stop_det
);

    logic scl_q;
    logic sda_q;

    // Previous-cycle line samples; idle bus level after reset.
    always_ff @(posedge pclk) begin
        if (preset) begin
            scl_q <= 1'b1;
            sda_q <= 1'b1;
        end else begin
            scl_q <= scl_in;
            sda_q <= sda_in;
        end
    end

    assign start_det = scl_in & scl_q &  sda_q & ~sda_in;
    assign stop_det  = scl_in & scl_q & ~sda_q &  sda_in;

endmodule

// File: rtl/i2c_slave_ctrl_fsm.sv
// I2C target bit/byte sequencer: address match, write/read bursts, ACK
// handling. Optional general-call support under I2C_SLAVE_GEN_CALL_EN.
module i2c_slave_ctrl_fsm
    import i2c_pkg::*;
#(
    parameter int unsigned BYTE_CNT_W = 8,
    parameter int unsigned MAX_BYTES  = 0
) (
    input  logic                   pclk,
    input  logic                   preset,
    i2c_slave_ctrl_fsm_if.slave    bus
);

    localparam logic [I2C_BIT_CNT_W-1:0] BIT_FULL = I2C_BIT_CNT_W'(I2C_BYTE_BITS);

    i2c_slv_state_e             state_q, state_d;
    logic [I2C_BIT_CNT_W-1:0]   bit_cnt_q, bit_cnt_d, bit_inc_c;
    logic [BYTE_CNT_W-1:0]      byte_cnt_q, byte_cnt_d;
    logic                       addr_match_q, addr_match_d;
    logic                       rw_q, rw_d;
    logic                       ack_q, ack_d;
    logic                       rack_nack_q, rack_nack_d;
    logic                       start_det, stop_det;
    logic                       ack_ok_c, match_c;
    logic                       sda_en_c, shift_en_c, shift_load_c, data_load_c, nack_rcvd_c;
    logic [I2C_ADDR_W-1:0]      addr_c;
`ifdef I2C_SLAVE_GEN_CALL_EN
    logic                       gen_call_q, gen_call_d, gc_c;
`endif

    i2c_bus_cond_det u_cond (
        .pclk      (pclk),
        .preset    (preset),
        .scl_in    (bus.scl_in),
        .sda_in    (bus.sda_in),
        .start_det (start_det),
        .stop_det  (stop_det)
    );

    // Address decode and write-ACK qualification.
    always_comb begin
        addr_c    = bus.rx_byte[I2C_BYTE_BITS-1:1];
        bit_inc_c = (bit_cnt_q < BIT_FULL) ? bit_cnt_q + I2C_BIT_CNT_W'(1) : bit_cnt_q;
        ack_ok_c  = bus.rx_ready & ((MAX_BYTES == 0) || (32'(byte_cnt_q) < MAX_BYTES));
`ifdef I2C_SLAVE_GEN_CALL_EN
        // General call only for writes; a general-call read is never ours.
        gc_c    = (addr_c == I2C_GEN_CALL_ADDR) & ~bus.rx_byte[0];
        match_c = ((addr_c == bus.own_addr) & ~((addr_c == I2C_GEN_CALL_ADDR) & bus.rx_byte[0])) | gc_c;
`else
        match_c = (addr_c == bus.own_addr);
`endif
    end

    // Next-state, counters and strobes; STOP beats START beats bit flow.
    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        byte_cnt_d   = byte_cnt_q;
        addr_match_d = addr_match_q;
        rw_d         = rw_q;
        ack_d        = ack_q;
        rack_nack_d  = rack_nack_q;
        shift_en_c   = 1'b0;
        shift_load_c = 1'b0;
        data_load_c  = 1'b0;
        nack_rcvd_c  = 1'b0;
        sda_en_c     = 1'b0;
`ifdef I2C_SLAVE_GEN_CALL_EN
        gen_call_d   = gen_call_q;
`endif

        case (state_q)
            ST_AACK: sda_en_c = addr_match_q;
            ST_WACK: sda_en_c = ack_q;
            ST_READ: sda_en_c = 1'b1;
            default: sda_en_c = 1'b0;
        endcase

        if (stop_det || start_det) begin
            state_d      = stop_det ? ST_IDLE : ST_ADDR;
            bit_cnt_d    = '0;
            byte_cnt_d   = '0;
            addr_match_d = 1'b0;
`ifdef I2C_SLAVE_GEN_CALL_EN
            gen_call_d   = 1'b0;
`endif
        end else begin
            case (state_q)
                ST_ADDR: begin
                    if (bus.tx_edge) begin
                        if (bit_cnt_q == BIT_FULL) begin
                            state_d      = ST_AACK;
                            bit_cnt_d    = '0;
                            addr_match_d = match_c;
                            rw_d         = bus.rx_byte[0];
`ifdef I2C_SLAVE_GEN_CALL_EN
                            gen_call_d   = gc_c;
`endif
                        end
                    end else if (bus.rx_edge) begin
                        shift_en_c = 1'b1;
                        bit_cnt_d  = bit_inc_c;
                    end
                end
                ST_AACK: begin
                    if (bus.tx_edge) begin
                        if (!addr_match_q) begin
                            state_d = ST_IDLE;
                        end else if (rw_q) begin
                            state_d      = ST_READ;
                            shift_load_c = 1'b1;
                        end else begin
                            state_d = ST_WRITE;
                        end
                    end
                end
                ST_WRITE: begin
                    if (bus.tx_edge) begin
                        if (bit_cnt_q == BIT_FULL) begin
                            state_d     = ST_WACK;
                            bit_cnt_d   = '0;
                            data_load_c = ack_ok_c;
                            ack_d       = ack_ok_c;
                            byte_cnt_d  = byte_cnt_q + BYTE_CNT_W'(1);
                        end
                    end else if (bus.rx_edge) begin
                        shift_en_c = 1'b1;
                        bit_cnt_d  = bit_inc_c;
                    end
                end
                ST_WACK: begin
                    if (bus.tx_edge) begin
                        state_d = ack_q ? ST_WRITE : ST_IDLE;
                    end
                end
                ST_READ: begin
                    if (bus.tx_edge) begin
                        if (bit_cnt_q == BIT_FULL) begin
                            state_d     = ST_RACK;
                            bit_cnt_d   = '0;
                            rack_nack_d = 1'b0;
                            byte_cnt_d  = byte_cnt_q + BYTE_CNT_W'(1);
                        end else begin
                            shift_en_c = 1'b1;
                        end
                    end else if (bus.rx_edge) begin
                        bit_cnt_d = bit_inc_c;
                    end
                end
                ST_RACK: begin
                    if (bus.tx_edge) begin
                        if (rack_nack_q) begin
                            state_d = ST_IDLE;
                        end else begin
                            state_d      = ST_READ;
                            shift_load_c = 1'b1;
                        end
                    end else if (bus.rx_edge) begin
                        rack_nack_d = bus.sda_in;
                        nack_rcvd_c = bus.sda_in;
                    end
                end
                default: state_d = state_q;
            endcase
        end
    end

    // State and context registers.
    always_ff @(posedge pclk) begin
        if (preset) begin
            state_q      <= ST_IDLE;
            bit_cnt_q    <= '0;
            byte_cnt_q   <= '0;
            addr_match_q <= 1'b0;
            rw_q         <= 1'b0;
            ack_q        <= 1'b0;
            rack_nack_q  <= 1'b0;
`ifdef I2C_SLAVE_GEN_CALL_EN
            gen_call_q   <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            byte_cnt_q   <= byte_cnt_d;
            addr_match_q <= addr_match_d;
            rw_q         <= rw_d;
            ack_q        <= ack_d;
            rack_nack_q  <= rack_nack_d;
`ifdef I2C_SLAVE_GEN_CALL_EN
            gen_call_q   <= gen_call_d;
`endif
        end
    end

    assign bus.sda_en        = sda_en_c;
    assign bus.shift_en      = shift_en_c;
    assign bus.shift_load_en = shift_load_c;
    assign bus.data_load_en  = data_load_c;
    assign bus.nack_rcvd     = nack_rcvd_c;
    assign bus.start_det     = start_det;
    assign bus.stop_det      = stop_det;
    assign bus.addr_match    = addr_match_q;
    assign bus.rw            = rw_q;
    assign bus.busy          = (state_q != ST_IDLE);
    assign bus.byte_cnt      = byte_cnt_q;
    assign bus.bit_cnt       = bit_cnt_q;
`ifdef I2C_SLAVE_GEN_CALL_EN
    assign bus.gen_call      = gen_call_q;
`endif

endmodule

// File: tb/tb_i2c_slave_ctrl_fsm.sv
// Directed bench for i2c_slave_ctrl_fsm: unlimited instance plus a
// MAX_BYTES=2 instance driven by the same bus stimulus.
module tb_i2c_slave_ctrl_fsm;

    logic       pclk = 1'b0;
    logic       preset;
    logic       rx_edge, tx_edge, scl, sda, rx_ready;
    logic [6:0] own_addr;
    logic [7:0] rx_byte;

    int n_tests = 0;
    int n_fail  = 0;

    int n_shift0 = 0, n_load0 = 0, n_data0 = 0, n_nack0 = 0;
    int n_start0 = 0, n_stop0 = 0, n_data2 = 0;
    logic [7:0] dlog [0:15];

    always #5 pclk = ~pclk;

    i2c_slave_ctrl_fsm_if #(.BYTE_CNT_W(8)) bus0 ();
    i2c_slave_ctrl_fsm_if #(.BYTE_CNT_W(8)) bus2 ();

    assign bus0.rx_edge = rx_edge;  assign bus2.rx_edge = rx_edge;
    assign bus0.tx_edge = tx_edge;  assign bus2.tx_edge = tx_edge;
    assign bus0.scl_in  = scl;      assign bus2.scl_in  = scl;
    assign bus0.sda_in  = sda;      assign bus2.sda_in  = sda;
    assign bus0.own_addr = own_addr; assign bus2.own_addr = own_addr;
    assign bus0.rx_byte = rx_byte;  assign bus2.rx_byte = rx_byte;
    assign bus0.rx_ready = rx_ready; assign bus2.rx_ready = rx_ready;

    i2c_slave_ctrl_fsm #(.BYTE_CNT_W(8), .MAX_BYTES(0)) u_dut0 (
        .pclk (pclk), .preset (preset), .bus (bus0)
    );
    i2c_slave_ctrl_fsm #(.BYTE_CNT_W(8), .MAX_BYTES(2)) u_dut2 (
        .pclk (pclk), .preset (preset), .bus (bus2)
    );

    // Strobe counters sampled mid-cycle.
    always @(negedge pclk) begin
        if (bus0.shift_en)      n_shift0++;
        if (bus0.shift_load_en) n_load0++;
        if (bus0.nack_rcvd)     n_nack0++;
        if (bus0.start_det)     n_start0++;
        if (bus0.stop_det)      n_stop0++;
        if (bus2.data_load_en)  n_data2++;
        if (bus0.data_load_en) begin
            dlog[4'(n_data0)] = bus0.rx_byte;
            n_data0++;
        end
    end

    task automatic cyc();
        @(posedge pclk); #1;
    endtask

    task automatic set_sda(input logic v);
        cyc(); sda = v;
    endtask

    task automatic rise();
        cyc(); scl = 1'b1; rx_edge = 1'b1;
        cyc(); rx_edge = 1'b0;
    endtask

    task automatic fall();
        cyc(); scl = 1'b0; tx_edge = 1'b1;
        cyc(); tx_edge = 1'b0;
    endtask

    task automatic bus_start();
        set_sda(1'b1); rise(); set_sda(1'b0); fall();
    endtask

    task automatic bus_stop();
        set_sda(1'b0); rise(); set_sda(1'b1); cyc();
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ack0, output logic ack2);
        rx_byte = b;
        for (int i = 7; i >= 0; i--) begin
            set_sda(b[i]); rise(); fall();
        end
        ack0 = bus0.sda_en;
        ack2 = bus2.sda_en;
        set_sda(1'b1); rise(); fall();
    endtask

    task automatic recv_byte(input logic mack, output logic drv);
        drv = bus0.sda_en;
        for (int i = 0; i < 8; i++) begin
            set_sda(1'b1); rise(); fall();
        end
        set_sda(mack); rise(); fall();
    endtask

    task automatic test_reset();
        preset = 1'b1; scl = 1'b1; sda = 1'b1; rx_edge = 1'b0; tx_edge = 1'b0;
        rx_ready = 1'b1; own_addr = 7'h50; rx_byte = 8'h00;
        cyc(); cyc();
        preset = 1'b0;
        cyc();
        n_tests++;
        if ({bus0.sda_en, bus0.shift_en, bus0.shift_load_en, bus0.data_load_en, bus0.addr_match,
             bus0.rw, bus0.nack_rcvd, bus0.start_det, bus0.stop_det, bus0.busy} !== 10'b0) begin
            n_fail++; $display("FAIL reset_flags: got nonzero outputs, want all 0");
        end
        n_tests++;
        if ({bus0.byte_cnt, bus0.bit_cnt} !== 12'h000) begin
            n_fail++; $display("FAIL reset_cnts: got %0h want 0", {bus0.byte_cnt, bus0.bit_cnt});
        end
    endtask

    task automatic test_write();
        int s_data = n_data0;
        int s_stop = n_stop0;
        logic [3:0] k = 4'(s_data);
        logic a0, a2, b0, c0;
        bus_start();
        send_byte(8'hA0, a0, a2);
        n_tests++;
        if (a0 !== 1'b1) begin n_fail++; $display("FAIL wr_addr_ack: got %b want 1", a0); end
        n_tests++;
        if ({bus0.addr_match, bus0.rw} !== 2'b10) begin
            n_fail++; $display("FAIL wr_match_rw: got %b want 10", {bus0.addr_match, bus0.rw});
        end
        send_byte(8'h11, b0, a2);
        send_byte(8'h22, c0, a2);
        n_tests++;
        if ({b0, c0} !== 2'b11) begin n_fail++; $display("FAIL wr_data_ack: got %b want 11", {b0, c0}); end
        n_tests++;
        if (n_data0 - s_data !== 2) begin
            n_fail++; $display("FAIL wr_load_cnt: got %0d want 2", n_data0 - s_data);
        end
        n_tests++;
        if ({dlog[k], dlog[k + 4'd1]} !== 16'h1122) begin
            n_fail++; $display("FAIL wr_load_data: got %h want 1122", {dlog[k], dlog[k + 4'd1]});
        end
        n_tests++;
        if (bus0.byte_cnt !== 8'd2) begin n_fail++; $display("FAIL wr_byte_cnt: got %0d want 2", bus0.byte_cnt); end
        bus_stop();
        n_tests++;
        if (n_stop0 - s_stop !== 1) begin n_fail++; $display("FAIL wr_stop_det: got %0d want 1", n_stop0 - s_stop); end
        n_tests++;
        if (bus0.busy !== 1'b0) begin n_fail++; $display("FAIL wr_busy_after_stop: got %b want 0", bus0.busy); end
    endtask

    task automatic test_addr_mismatch();
        int s_shift;
        logic a0, a2;
        bus_start();
        send_byte(8'hA2, a0, a2);
        n_tests++;
        if (a0 !== 1'b0) begin n_fail++; $display("FAIL mis_ack: got %b want 0", a0); end
        n_tests++;
        if ({bus0.busy, bus0.addr_match} !== 2'b00) begin
            n_fail++; $display("FAIL mis_idle: got %b want 00", {bus0.busy, bus0.addr_match});
        end
        s_shift = n_shift0;
        for (int i = 0; i < 8; i++) begin
            set_sda(i[0]); rise(); fall();
        end
        n_tests++;
        if (n_shift0 - s_shift !== 0) begin
            n_fail++; $display("FAIL mis_no_shift: got %0d want 0", n_shift0 - s_shift);
        end
        bus_stop();
    endtask

    task automatic test_read();
        int s_load = n_load0;
        int s_nack = n_nack0;
        int s_shift = n_shift0;
        logic a0, a2, d;
        bus_start();
        send_byte(8'hA1, a0, a2);
        n_tests++;
        if (a0 !== 1'b1) begin n_fail++; $display("FAIL rd_addr_ack: got %b want 1", a0); end
        n_tests++;
        if (n_load0 - s_load !== 1) begin n_fail++; $display("FAIL rd_first_load: got %0d want 1", n_load0 - s_load); end
        recv_byte(1'b0, d);
        n_tests++;
        if (d !== 1'b1) begin n_fail++; $display("FAIL rd_sda_drive: got %b want 1", d); end
        recv_byte(1'b0, d);
        recv_byte(1'b1, d);
        n_tests++;
        if (n_load0 - s_load !== 3) begin n_fail++; $display("FAIL rd_load_cnt: got %0d want 3", n_load0 - s_load); end
        n_tests++;
        if (n_nack0 - s_nack !== 1) begin n_fail++; $display("FAIL rd_nack_cnt: got %0d want 1", n_nack0 - s_nack); end
        n_tests++;
        if (n_shift0 - s_shift !== 29) begin n_fail++; $display("FAIL rd_shift_cnt: got %0d want 29", n_shift0 - s_shift); end
        n_tests++;
        if ({bus0.busy, bus0.byte_cnt} !== 9'h003) begin
            n_fail++; $display("FAIL rd_end_state: got %h want 003", {bus0.busy, bus0.byte_cnt});
        end
        bus_stop();
    endtask

    task automatic test_max_bytes();
        int s2 = n_data2;
        int s0;
        logic a0, a2, x0, x1, x2, y0;
        bus_start();
        send_byte(8'hA0, a0, a2);
        send_byte(8'h01, a0, x0);
        send_byte(8'h02, a0, x1);
        send_byte(8'h03, y0, x2);
        n_tests++;
        if ({x0, x1, x2} !== 3'b110) begin n_fail++; $display("FAIL max_acks: got %b want 110", {x0, x1, x2}); end
        n_tests++;
        if (n_data2 - s2 !== 2) begin n_fail++; $display("FAIL max_load_cnt: got %0d want 2", n_data2 - s2); end
        n_tests++;
        if (bus2.busy !== 1'b0) begin n_fail++; $display("FAIL max_idle: got %b want 0", bus2.busy); end
        n_tests++;
        if (y0 !== 1'b1) begin n_fail++; $display("FAIL unlim_third_ack: got %b want 1", y0); end
        s0 = n_data0;
        rx_ready = 1'b0;
        send_byte(8'h04, a0, a2);
        rx_ready = 1'b1;
        n_tests++;
        if ({a0, bus0.busy} !== 2'b00 || n_data0 != s0) begin
            n_fail++; $display("FAIL not_ready_nack: got ack=%b busy=%b loads=%0d want 0 0 0", a0, bus0.busy, n_data0 - s0);
        end
        bus_stop();
    endtask

    task automatic test_rep_start();
        int s_start;
        logic a0, a2, d;
        bus_start();
        send_byte(8'hA0, a0, a2);
        send_byte(8'h11, a0, a2);
        n_tests++;
        if (bus0.byte_cnt !== 8'd1) begin n_fail++; $display("FAIL rs_cnt_before: got %0d want 1", bus0.byte_cnt); end
        s_start = n_start0;
        bus_start();
        n_tests++;
        if (n_start0 - s_start !== 1) begin n_fail++; $display("FAIL rs_start_det: got %0d want 1", n_start0 - s_start); end
        n_tests++;
        if ({bus0.byte_cnt, bus0.bit_cnt, bus0.addr_match} !== 13'h0) begin
            n_fail++; $display("FAIL rs_cleared: got cnt=%0d bits=%0d match=%b want 0 0 0", bus0.byte_cnt, bus0.bit_cnt, bus0.addr_match);
        end
        send_byte(8'hA1, a0, a2);
        n_tests++;
        if ({bus0.rw, bus0.busy, bus0.sda_en} !== 3'b111) begin
            n_fail++; $display("FAIL rs_read_entry: got %b want 111", {bus0.rw, bus0.busy, bus0.sda_en});
        end
        recv_byte(1'b1, d);
        n_tests++;
        if (bus0.busy !== 1'b0) begin n_fail++; $display("FAIL rs_idle: got %b want 0", bus0.busy); end
        bus_stop();
    endtask

    task automatic test_reset_mid_write();
        logic a0, a2;
        bus_start();
        send_byte(8'hA0, a0, a2);
        for (int i = 0; i < 4; i++) begin
            set_sda(1'b1); rise(); fall();
        end
        n_tests++;
        if ({bus0.busy, bus0.bit_cnt} !== 5'b1_0100) begin
            n_fail++; $display("FAIL mr_pre: got %b want 10100", {bus0.busy, bus0.bit_cnt});
        end
        cyc(); preset = 1'b1;
        cyc(); preset = 1'b0;
        n_tests++;
        if ({bus0.sda_en, bus0.shift_en, bus0.shift_load_en, bus0.data_load_en, bus0.addr_match,
             bus0.rw, bus0.nack_rcvd, bus0.start_det, bus0.stop_det, bus0.busy,
             bus0.byte_cnt, bus0.bit_cnt} !== 22'h0) begin
            n_fail++; $display("FAIL mr_cleared: got busy=%b bits=%0d match=%b want all 0", bus0.busy, bus0.bit_cnt, bus0.addr_match);
        end
        bus_start();
        n_tests++;
        if ({bus0.busy, bus0.addr_match, bus0.bit_cnt} !== 6'b10_0000) begin
            n_fail++; $display("FAIL mr_clean_addr: got %b want 100000", {bus0.busy, bus0.addr_match, bus0.bit_cnt});
        end
        send_byte(8'hA0, a0, a2);
        n_tests++;
        if (a0 !== 1'b1) begin n_fail++; $display("FAIL mr_addr_ack: got %b want 1", a0); end
        bus_stop();
    endtask

    initial begin
        test_reset();
        test_write();
        test_addr_mismatch();
        test_read();
        test_max_bytes();
        test_rep_start();
        test_reset_mid_write();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
